// File: rtl/calc_nport_engine.sv
// N-port calculator engine: per-port two-cycle request capture into a small
// FIFO, a round-robin arbiter picking one FIFO head per cycle, and a single
// shared ALU whose result is registered onto the originating port's outputs.
module calc_nport_engine #(
    parameter int unsigned N_PORTS = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TAG_W   = 2,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                      c_clk,
    input  logic                      reset,
    input  logic [N_PORTS*4-1:0]      req_cmd_in,
    input  logic [N_PORTS*DATA_W-1:0] req_data_in,
    input  logic [N_PORTS*TAG_W-1:0]  req_tag_in,
    output logic [N_PORTS-1:0]        req_ready,
    output logic [N_PORTS*2-1:0]      out_resp,
    output logic [N_PORTS*DATA_W-1:0] out_data,
    output logic [N_PORTS*TAG_W-1:0]  out_tag
);

    localparam int unsigned SH_W  = $clog2(DATA_W);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    localparam logic [3:0] CmdAdd = 4'd1;
    localparam logic [3:0] CmdSub = 4'd2;
    localparam logic [3:0] CmdShl = 4'd5;
    localparam logic [3:0] CmdShr = 4'd6;

    localparam logic [1:0] RespOk  = 2'b01;
    localparam logic [1:0] RespErr = 2'b10;

    typedef enum logic [0:0] {StIdle, StOp2} cap_state_e;

    // Capture stage
    cap_state_e        state_q [N_PORTS];
    logic [3:0]        cmd_q   [N_PORTS];
    logic [DATA_W-1:0] op1_q   [N_PORTS];
    logic [TAG_W-1:0]  tag_q   [N_PORTS];

    // Per-port request FIFOs
    logic [3:0]        fifo_cmd [N_PORTS][DEPTH];
    logic [DATA_W-1:0] fifo_op1 [N_PORTS][DEPTH];
    logic [DATA_W-1:0] fifo_op2 [N_PORTS][DEPTH];
    logic [TAG_W-1:0]  fifo_tag [N_PORTS][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [N_PORTS];
    logic [PTR_W-1:0]  rd_ptr_q [N_PORTS];
    logic [CNT_W-1:0]  count_q  [N_PORTS];

    // Arbitration
    logic [IDX_W-1:0]   rr_ptr_q;
    logic               grant_valid;
    logic [IDX_W-1:0]   grant_idx;
    logic [N_PORTS-1:0] accept;
    logic [N_PORTS-1:0] push;
    logic [N_PORTS-1:0] pop;

    // Shared ALU
    logic [3:0]        alu_cmd;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [TAG_W-1:0]  alu_tag;
    logic [DATA_W:0]   alu_sum;
    logic [DATA_W-1:0] alu_data;
    logic [1:0]        alu_resp;

    // Ready/accept per port; ready is held low while reset is asserted
    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            req_ready[p] = reset && (state_q[p] == StIdle) && (count_q[p] < CNT_W'(DEPTH));
            accept[p]    = req_ready[p] && (req_cmd_in[p*4 +: 4] != 4'd0);
            push[p]      = (state_q[p] == StOp2);
        end
    end

    // Capture FSM: command cycle latches cmd/op1/tag, next cycle supplies op2
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < N_PORTS; p++) begin
                state_q[p] <= StIdle;
                cmd_q[p]   <= '0;
                op1_q[p]   <= '0;
                tag_q[p]   <= '0;
            end
        end else begin
            for (int p = 0; p < N_PORTS; p++) begin
                case (state_q[p])
                    StIdle: begin
                        if (accept[p]) begin
                            state_q[p] <= StOp2;
                            cmd_q[p]   <= req_cmd_in[p*4 +: 4];
                            op1_q[p]   <= req_data_in[p*DATA_W +: DATA_W];
                            tag_q[p]   <= req_tag_in[p*TAG_W +: TAG_W];
                        end
                    end
                    StOp2:   state_q[p] <= StIdle;
                    default: state_q[p] <= StIdle;
                endcase
            end
        end
    end

    // FIFO storage; contents are only meaningful below count_q, so no reset
    always_ff @(posedge c_clk) begin
        for (int p = 0; p < N_PORTS; p++) begin
            if (push[p]) begin
                fifo_cmd[p][wr_ptr_q[p]] <= cmd_q[p];
                fifo_op1[p][wr_ptr_q[p]] <= op1_q[p];
                fifo_op2[p][wr_ptr_q[p]] <= req_data_in[p*DATA_W +: DATA_W];
                fifo_tag[p][wr_ptr_q[p]] <= tag_q[p];
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < N_PORTS; p++) begin
                wr_ptr_q[p] <= '0;
                rd_ptr_q[p] <= '0;
                count_q[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < N_PORTS; p++) begin
                wr_ptr_q[p] <= wr_ptr_q[p] + PTR_W'(push[p]);
                rd_ptr_q[p] <= rd_ptr_q[p] + PTR_W'(pop[p]);
                count_q[p]  <= count_q[p] + CNT_W'(push[p]) - CNT_W'(pop[p]);
            end
        end
    end

    // Round-robin grant over FIFOs non-empty at cycle start, searching from rr_ptr_q
    always_comb begin
        int cand;
        cand        = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        pop         = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= int'(N_PORTS)) cand = cand - int'(N_PORTS);
            if (!grant_valid && (count_q[cand] != '0)) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
        if (grant_valid) pop[grant_idx] = 1'b1;
    end

    // Pointer moves just past the winner; idle cycles leave it alone
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= '0;
        end else if (grant_valid) begin
            rr_ptr_q <= (grant_idx == IDX_W'(N_PORTS - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    // ALU on the granted FIFO head; errors and unknown commands return data 0
    always_comb begin
        alu_cmd  = fifo_cmd[grant_idx][rd_ptr_q[grant_idx]];
        alu_a    = fifo_op1[grant_idx][rd_ptr_q[grant_idx]];
        alu_b    = fifo_op2[grant_idx][rd_ptr_q[grant_idx]];
        alu_tag  = fifo_tag[grant_idx][rd_ptr_q[grant_idx]];
        alu_sum  = {1'b0, alu_a} + {1'b0, alu_b};
        alu_resp = RespErr;
        alu_data = '0;
        case (alu_cmd)
            CmdAdd: begin
                if (!alu_sum[DATA_W]) begin
                    alu_resp = RespOk;
                    alu_data = alu_sum[DATA_W-1:0];
                end
            end
            CmdSub: begin
                if (alu_b <= alu_a) begin
                    alu_resp = RespOk;
                    alu_data = alu_a - alu_b;
                end
            end
            CmdShl: begin
                alu_resp = RespOk;
                alu_data = alu_a << alu_b[SH_W-1:0];
            end
            CmdShr: begin
                alu_resp = RespOk;
                alu_data = alu_a >> alu_b[SH_W-1:0];
            end
            default: ;
        endcase
    end

    // Result register: one-cycle pulse on the granted port, zeros elsewhere
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            out_resp <= '0;
            out_data <= '0;
            out_tag  <= '0;
        end else begin
            out_resp <= '0;
            out_data <= '0;
            out_tag  <= '0;
            for (int p = 0; p < N_PORTS; p++) begin
                if (pop[p]) begin
                    out_resp[p*2 +: 2]           <= alu_resp;
                    out_data[p*DATA_W +: DATA_W] <= alu_data;
                    out_tag[p*TAG_W +: TAG_W]    <= alu_tag;
                end
            end
        end
    end

endmodule

// File: tb/tb_calc_nport_engine.sv
// Bench for calc_nport_engine: directed and random traffic against a
// cycle-level reference model; a monitor compares every port every cycle.
module tb_calc_nport_engine;

    localparam int N = 4;
    localparam int W = 32;
    localparam int T = 2;
    localparam int D = 4;

    logic           c_clk = 1'b0;
    logic           rst_n;
    logic [N*4-1:0] req_cmd_in;
    logic [N*W-1:0] req_data_in;
    logic [N*T-1:0] req_tag_in;
    logic [N-1:0]   req_ready;
    logic [N*2-1:0] out_resp;
    logic [N*W-1:0] out_data;
    logic [N*T-1:0] out_tag;

    // Narrow two-port build
    logic [7:0]  cmd2;
    logic [15:0] data2;
    logic [7:0]  tag2;
    logic [1:0]  ready2;
    logic [3:0]  resp2;
    logic [15:0] odata2;
    logic [7:0]  otag2;

    calc_nport_engine #(.N_PORTS(N), .DATA_W(W), .TAG_W(T), .DEPTH(D)) dut (
        .c_clk       (c_clk),
        .reset       (rst_n),
        .req_cmd_in  (req_cmd_in),
        .req_data_in (req_data_in),
        .req_tag_in  (req_tag_in),
        .req_ready   (req_ready),
        .out_resp    (out_resp),
        .out_data    (out_data),
        .out_tag     (out_tag)
    );

    calc_nport_engine #(.N_PORTS(2), .DATA_W(8), .TAG_W(4), .DEPTH(2)) dut2 (
        .c_clk       (c_clk),
        .reset       (rst_n),
        .req_cmd_in  (cmd2),
        .req_data_in (data2),
        .req_tag_in  (tag2),
        .req_ready   (ready2),
        .out_resp    (resp2),
        .out_data    (odata2),
        .out_tag     (otag2)
    );

    always #5 c_clk = ~c_clk;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [1:0]  tag;
    } req_t;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        logic [1:0]  tag;
        int          due;
    } exp_t;

    req_t        script [N][$];   // commands each port will present
    exp_t        mq     [N][$];   // model of queued requests per port
    exp_t        sb     [N][$];   // scoreboard: granted, awaiting output
    bit          m_op2    [N];
    logic [3:0]  m_cmd    [N];
    logic [31:0] m_op1    [N];
    logic [1:0]  m_tag    [N];
    logic [31:0] pend_op2 [N];
    int          mptr;
    int          cyc;
    int          errs;
    int          checks;

    task automatic chk(string name, int p, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            if (errs <= 40)
                $display("FAIL %s port%0d cycle %0d: got %0h expected %0h", name, p, cyc, act, exp);
        end
    endtask

    function automatic exp_t ref_model(logic [3:0] cmd, logic [31:0] a, logic [31:0] b,
                                       logic [1:0] tag);
        exp_t   e;
        longint sum;
        e.tag  = tag;
        e.due  = 0;
        e.resp = 2'b10;
        e.data = 32'd0;
        case (cmd)
            4'd1: begin
                sum = longint'(a) + longint'(b);
                if (sum <= 64'hFFFF_FFFF) begin
                    e.resp = 2'b01;
                    e.data = sum[31:0];
                end
            end
            4'd2: begin
                if (a >= b) begin
                    e.resp = 2'b01;
                    e.data = a - b;
                end
            end
            4'd5: begin
                e.resp = 2'b01;
                e.data = a << b[4:0];
            end
            4'd6: begin
                e.resp = 2'b01;
                e.data = a >> b[4:0];
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic req_t mk(logic [3:0] cmd, logic [31:0] a, logic [31:0] b, logic [1:0] tag);
        req_t r;
        r.cmd = cmd;
        r.op1 = a;
        r.op2 = b;
        r.tag = tag;
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t       r;
        int         k;
        logic [3:0] inv [5];
        inv = '{4'd3, 4'd4, 4'd7, 4'd8, 4'd15};
        k = $urandom_range(0, 9);
        case (k)
            0:       r.cmd = 4'd0;
            1, 2:    r.cmd = 4'd1;
            3, 4:    r.cmd = 4'd2;
            5, 6:    r.cmd = 4'd5;
            7, 8:    r.cmd = 4'd6;
            default: r.cmd = inv[$urandom_range(0, 4)];
        endcase
        r.op1 = $urandom;
        r.op2 = $urandom;
        if ($urandom_range(0, 3) == 0) r.op1 = 32'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) r.op2 = 32'($urandom_range(0, 15));
        r.tag = 2'($urandom);
        return r;
    endfunction

    // Reference model: one step per rising edge, from the rules of the block
    task automatic model_step();
        bit   rdy [N];
        bit   g;
        int   idx;
        exp_t e;
        for (int p = 0; p < N; p++) rdy[p] = !m_op2[p] && (mq[p].size() < D);
        g = 0;
        for (int i = 0; i < N; i++) begin
            idx = (mptr + i) % N;
            if (!g && mq[idx].size() > 0) begin
                e     = mq[idx].pop_front();
                e.due = cyc;
                sb[idx].push_back(e);
                mptr  = (idx + 1) % N;
                g     = 1;
            end
        end
        for (int p = 0; p < N; p++) begin
            if (m_op2[p]) begin
                mq[p].push_back(ref_model(m_cmd[p], m_op1[p], req_data_in[p*W +: W], m_tag[p]));
                m_op2[p] = 0;
            end else if (rdy[p] && req_cmd_in[p*4 +: 4] != 4'd0) begin
                m_op2[p] = 1;
                m_cmd[p] = req_cmd_in[p*4 +: 4];
                m_op1[p] = req_data_in[p*W +: W];
                m_tag[p] = req_tag_in[p*T +: T];
            end
        end
    endtask

    initial begin
        cyc  = 0;
        mptr = 0;
        forever begin
            @(posedge c_clk);
            cyc++;
            if (rst_n === 1'b1) model_step();
        end
    end

    task automatic mon_port(int p);
        exp_t e;
        e.resp = 2'b00;
        e.data = 32'd0;
        e.tag  = 2'b00;
        e.due  = 0;
        if (sb[p].size() > 0 && sb[p][0].due == cyc) e = sb[p].pop_front();
        chk("resp", p, 64'(out_resp[p*2 +: 2]), 64'(e.resp));
        chk("data", p, 64'(out_data[p*W +: W]), 64'(e.data));
        chk("tag", p, 64'(out_tag[p*T +: T]), 64'(e.tag));
        chk("ready", p, 64'(req_ready[p]), 64'(!m_op2[p] && (mq[p].size() < D)));
    endtask

    // Monitor: compare every port at the falling edge
    initial begin
        forever begin
            @(negedge c_clk);
            if (rst_n === 1'b1)
                for (int p = 0; p < N; p++) mon_port(p);
        end
    end

    task automatic drive();
        req_t s;
        @(negedge c_clk);
        for (int p = 0; p < N; p++) begin
            if (m_op2[p]) begin
                req_cmd_in[p*4 +: 4]  = 4'($urandom);
                req_data_in[p*W +: W] = pend_op2[p];
                req_tag_in[p*T +: T]  = 2'($urandom);
            end else if (script[p].size() > 0) begin
                s = script[p].pop_front();
                req_cmd_in[p*4 +: 4]  = s.cmd;
                req_data_in[p*W +: W] = s.op1;
                req_tag_in[p*T +: T]  = s.tag;
                pend_op2[p]           = s.op2;
            end else begin
                req_cmd_in[p*4 +: 4]  = 4'd0;
                req_data_in[p*W +: W] = $urandom;
                req_tag_in[p*T +: T]  = 2'($urandom);
            end
        end
    endtask

    task automatic run(int n);
        repeat (n) drive();
    endtask

    task automatic run_until_idle(int limit);
        int n;
        int left;
        n    = 0;
        left = 1;
        while (left > 0 && n < limit) begin
            drive();
            n++;
            left = 0;
            for (int p = 0; p < N; p++) left += script[p].size();
        end
        if (left > 0) begin
            checks++;
            errs++;
            $display("FAIL drain: %0d commands left after %0d cycles, required 0", left, n);
        end
        run(30);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, errors=%0d of %0d checks", errs, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        bit seen0;
        bit seen1;
        errs        = 0;
        checks      = 0;
        rst_n       = 1'b0;
        req_cmd_in  = '0;
        req_data_in = '0;
        req_tag_in  = '0;
        cmd2        = '0;
        data2       = '0;
        tag2        = '0;
        for (int p = 0; p < N; p++) begin
            m_op2[p]    = 0;
            pend_op2[p] = '0;
        end

        // Reset state
        repeat (3) @(negedge c_clk);
        chk("rst_resp", 0, 64'(out_resp), 64'd0);
        chk("rst_data", 0, 64'(out_data[63:0]), 64'd0);
        chk("rst_ready", 0, 64'(req_ready), 64'd0);
        #2 rst_n = 1'b1;
        #1 chk("ready_after_release", 0, 64'(req_ready), 64'hF);

        // Single uncontended add
        script[1].push_back(mk(4'd1, 32'h10, 32'h20, 2'd1));
        run(10);

        // Overflow, underflow, shift amount masking, invalid command
        script[1].push_back(mk(4'd1, 32'hFFFF_FFFF, 32'd1, 2'd2));
        script[2].push_back(mk(4'd2, 32'd5, 32'd6, 2'd3));
        script[3].push_back(mk(4'd5, 32'd1, 32'h25, 2'd0));
        script[0].push_back(mk(4'd3, 32'd7, 32'd9, 2'd1));
        run(12);

        // All four ports on the same cycle
        for (int p = 0; p < N; p++) script[p].push_back(mk(4'd1, 32'(p), 32'd100, 2'(p)));
        run(15);

        // Port 0 floods while the others keep the arbiter busy
        for (int i = 0; i < 12; i++) script[0].push_back(mk(4'd1, 32'(i), 32'd1, 2'(i)));
        for (int p = 1; p < N; p++)
            for (int i = 0; i < 8; i++) script[p].push_back(mk(4'd2, 32'd50, 32'(i), 2'(p)));
        run_until_idle(200);

        // Random traffic
        for (int round = 0; round < 8; round++) begin
            for (int p = 0; p < N; p++)
                repeat ($urandom_range(0, 16)) script[p].push_back(rand_req());
            run_until_idle(300);
        end

        // Reset in port 1's op2 cycle with at least two entries queued on port 2
        for (int p = 0; p < N; p++)
            repeat (20) script[p].push_back(mk(4'd1, $urandom, 32'd3, 2'($urandom)));
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            drive();
            if (m_op2[1] && mq[2].size() >= 2) found = 1;
        end
        checks++;
        if (!found) begin
            errs++;
            $display("FAIL reset_setup: queue condition not reached, required within 200 cycles");
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_resp", 0, 64'(out_resp), 64'd0);
        chk("midrst_tag", 0, 64'(out_tag), 64'd0);
        chk("midrst_ready", 0, 64'(req_ready), 64'd0);
        for (int p = 0; p < N; p++) begin
            script[p].delete();
            mq[p].delete();
            sb[p].delete();
            m_op2[p] = 0;
        end
        mptr        = 0;
        req_cmd_in  = '0;
        req_data_in = '0;
        @(negedge c_clk);
        #2 rst_n = 1'b1;
        #1 chk("ready_after_midrst", 0, 64'(req_ready), 64'hF);
        run(12);

        // Post-reset traffic: pointer restarts at port 0
        for (int p = 0; p < N; p++) script[p].push_back(mk(4'd6, 32'h8000_0000, 32'(p + 1), 2'(p)));
        run(15);

        // Narrow build: 8-bit data, 4-bit tags
        @(negedge c_clk);
        cmd2  = {4'd6, 4'd1};
        data2 = {8'hF0, 8'h80};
        tag2  = {4'hA, 4'h3};
        @(negedge c_clk);
        cmd2  = {4'h9, 4'h9};
        data2 = {8'h04, 8'h80};
        @(negedge c_clk);
        cmd2  = '0;
        seen0 = 0;
        seen1 = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge c_clk);
            if (resp2[1:0] != 2'b00) begin
                seen0 = 1;
                chk("n2_cycle", 0, 64'(i), 64'd0);
                chk("n2_resp", 0, 64'(resp2[1:0]), 64'h2);
                chk("n2_data", 0, 64'(odata2[7:0]), 64'h0);
                chk("n2_tag", 0, 64'(otag2[3:0]), 64'h3);
            end
            if (resp2[3:2] != 2'b00) begin
                seen1 = 1;
                chk("n2_cycle", 1, 64'(i), 64'd1);
                chk("n2_resp", 1, 64'(resp2[3:2]), 64'h1);
                chk("n2_data", 1, 64'(odata2[15:8]), 64'h0F);
                chk("n2_tag", 1, 64'(otag2[7:4]), 64'hA);
            end
        end
        chk("n2_seen", 0, 64'(seen0), 64'd1);
        chk("n2_seen", 1, 64'(seen1), 64'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/calc_nport_engine.md
Name: calc_nport_engine

Overview:
- Parametrised successor to the four-port Calc2 engine: N requester ports, configurable data and tag widths.
- Per-port request FIFOs with backpressure, a round-robin arbiter and a single shared ALU.
- Results are routed back to the originating port with the requester's tag.
- Sits under the top-level bench in place of the fixed four-port calculator; driven by the shared calc bus interface.

Parameters:
- N_PORTS, 4, number of requester ports (1..8)
- DATA_W, 32, operand/result width
- TAG_W, 2, tag width per request
- DEPTH, 4, request FIFO entries per port (power of two, >=2)

Ports:
- c_clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- req_cmd_in  input  N_PORTS*4  per-port command: 0 nop, 1 add, 2 sub, 5 shl, 6 shr; others invalid
- req_data_in  input  N_PORTS*DATA_W  per-port operand (op1 on command cycle, op2 on following cycle)
- req_tag_in  input  N_PORTS*TAG_W  per-port tag, sampled on command cycle
- req_ready  output  N_PORTS  port may issue a command this cycle
- out_resp  output  N_PORTS*2  00 none, 01 success, 10 overflow/underflow/invalid, 11 unused
- out_data  output  N_PORTS*DATA_W  result, valid when out_resp != 0
- out_tag  output  N_PORTS*TAG_W  tag of the completed request

Behaviour:
- Reset (reset=0, asynchronous):
  - all out_resp/out_data/out_tag = 0; req_ready = 0.
  - FIFOs emptied, capture FSMs to IDLE, round-robin pointer = 0.
  - Partial or queued requests are discarded, no response.
  - First cycle after release: req_ready = 1 for every port.
- Per-port capture FSM:
  - IDLE: cmd != 0 and req_ready = 1 → latch cmd, op1, tag; go to OP2.
  - OP2: latch data as op2 (cmd ignored), push {cmd, op1, op2, tag} into the port FIFO, go to IDLE.
  - No back-to-back commands: the next command is accepted no earlier than the cycle after OP2.
- Backpressure:
  - req_ready = (state == IDLE) && (fifo_count < DEPTH).
  - A command presented while req_ready = 0 is dropped silently, and no response is ever generated for it.
  - Only the owning port pushes its FIFO, so a slot checked at command time is guaranteed at push time.
- Invalid commands are accepted and queued like valid ones; they complete with resp 10 and data 0.
- Arbiter:
  - Each cycle, grant one non-empty FIFO, round-robin starting at the pointer.
  - On grant, pointer = granted + 1 (mod N_PORTS); no grant leaves the pointer unchanged.
  - Granted FIFO pops the same cycle.
- ALU:
  - Combinational on the popped entry; registered into the granted port's outputs at the end of the grant cycle.
  - Outputs held for exactly one cycle; other ports' outputs are 0 that cycle.
- Latency: op2 in cycle k, uncontended → response visible in cycle k+2. Each queued competitor adds one cycle.
- Arithmetic, unsigned DATA_W:
  - add: carry-out → resp 10, data 0; else resp 01, data = sum.
  - sub: op2 > op1 → resp 10, data 0; else resp 01, data = op1 - op2.
  - shl/shr: shift amount = op2[$clog2(DATA_W)-1:0], logical, resp 01; upper op2 bits ignored.
- Simultaneous events:
  - Push and pop on the same FIFO in one cycle: count unchanged.
  - A FIFO that is empty at the start of the cycle cannot be granted in that cycle.
- FIFO pointers wrap modulo DEPTH; count saturates at DEPTH by construction; the full flag drives req_ready low.
- Per-port ordering: responses in request order. Cross-port ordering is set by arbitration only.

Test Plan:
- Reset release, port1 add 0x0000_0010 + 0x0000_0020, tag 1 → port1 resp 01, data 0x30, tag 1, two cycles after op2; other ports resp 00.
- Port2 add 0xFFFF_FFFF + 1 → resp 10, data 0. Port3 sub 5 - 6 → resp 10. Port4 shl 1 by 0x25 → data 0x20 (amount 5), resp 01. Port1 cmd 3 → resp 10, data 0.
- All four ports issue add on the same cycle, pointer 0 → responses on ports 1,2,3,4 in consecutive cycles k+2..k+5.
- Port1 issues DEPTH+1 commands while the other ports saturate the arbiter → req_ready falls after DEPTH pushes, the extra command is dropped, exactly DEPTH responses in order.
- Reset asserted in the OP2 cycle of port2, with port3 holding two queued entries → outputs 0 immediately; no response for any of those requests after release.
- N_PORTS=2, DATA_W=8, TAG_W=4 build: add 0x80 + 0x80 → resp 10; shr 0xF0 by 4 → 0x0F, tag 0xA returned intact.
